sdram_bram_responder: RTL
=========================

Name: sdram_bram_responder

Overview:
- Responder end of the SDRAM controller user interface: addr/rw/data_in/in_valid in, busy/data_out/out_valid out.
- Backs the interface with on-chip block RAM.
- Emulates controller timing: init hold-off, fixed read latency, periodic refresh stalls.
- Lets the ram_test-style traffic generator and MCS memory clients run on hardware or in simulation without the SDRAM shield.

Parameters:
ADDR_BITS, 10, number of implemented word-address bits; depth = 2^ADDR_BITS 32-bit words
READ_LATENCY, 3, cycles from read acceptance to out_valid; legal range 1..8
REFRESH_PERIOD, 780, cycles of availability between refresh windows; must be at least 2
REFRESH_CYCLES, 8, cycles busy is held per refresh window; must be at least 1
INIT_CYCLES, 16, cycles busy is held after reset release; must be at least 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
addr  input  23  word address of request
rw  input  1  1 = write, 0 = read
data_in  input  32  write data
in_valid  input  1  request strobe
busy  output  1  responder cannot accept a request this cycle
data_out  output  32  read data
out_valid  output  1  data_out valid, single-cycle pulse per read

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - busy=1, out_valid=0, data_out=0.
  - Timer is in INIT, counter=0.
  - Read pipeline is flushed.
  - Memory contents are not cleared; a read before any write to that location returns undefined data.
- Acceptance:
  - A request is accepted in a cycle where in_valid=1 and busy=0.
  - When busy=1, in_valid is ignored with no side effects; the initiator re-presents the request.
- Address mapping:
  - Only addr[ADDR_BITS-1:0] is used. Upper bits are ignored, so addresses alias modulo 2^ADDR_BITS.
- Write:
  - The memory is updated at the clock edge ending the accept cycle. No response is generated.
- Read:
  - Memory is sampled at the accept edge.
  - data_out and out_valid=1 appear exactly READ_LATENCY cycles after the accept cycle, held for one cycle.
  - data_out holds its last value while out_valid=0.
- Ordering and pipelining:
  - Reads complete in issue order.
  - Back-to-back reads, one per cycle, are fully pipelined, giving one out_valid per cycle.
  - A read pipeline of READ_LATENCY valid bits carries the valid flag.
- Hazards:
  - Write then read of the same address on the next cycle returns the new data.
  - Read in the same cycle as a write is impossible, since there is one request per cycle.
- Timer state machine (busy generator):
  - INIT: busy=1. Counts INIT_CYCLES cycles, then goes to RUN with counter=0.
  - RUN: busy=0. Counts REFRESH_PERIOD cycles. On the last RUN cycle, busy is still 0 and a request presented then is accepted; the next cycle enters REFRESH.
  - REFRESH: busy=1 for exactly REFRESH_CYCLES cycles, then returns to RUN with counter=0.
  - Illegal state: goes to INIT.
- Refresh does not stall the read pipeline. Reads accepted before REFRESH still return out_valid on schedule, during the REFRESH window.
- Reset mid-operation:
  - All in-flight reads are dropped; no out_valid until a new read is accepted.
  - Timer restarts at INIT.
  - Memory keeps its contents.
- Counter widths: sized with clog2 of the largest of INIT_CYCLES, REFRESH_PERIOD and REFRESH_CYCLES. No wrap beyond terminal counts.

Decomposition:
- Shared package/header holds the interface constants: SDRAM_ADDR_W=23, SDRAM_DATA_W=32, and the timer state encodings INIT/RUN/REFRESH.
- One natural sub-module, sdram_busy_gen: the INIT/RUN/REFRESH timer that produces registered busy.
- The top level holds the BRAM array, the read-data register chain, and the valid shift register.

Test Plan:
1. Reset sequence: hold rst for 5 cycles, then release → busy=1 for exactly 16 cycles after release, then busy=0; out_valid=0 throughout.
2. Write/read round trip: write 0xDEADBEEF to addr 5, then read addr 5 on the next cycle → out_valid for exactly one cycle, 3 cycles after read accept, with data_out=0xDEADBEEF.
3. Streaming: write PRNG values to addrs 0..63, then issue 64 back-to-back reads → 64 consecutive out_valid pulses in order, zero mismatches; ram_test-style error count stays 0.
4. Refresh boundary: present a read on the last RUN cycle (cycle 780 after RUN entry) → request accepted; busy=1 for the next 8 cycles; the in_valid held during those 8 cycles is not accepted; the read still returns out_valid 3 cycles after accept, during refresh.
5. Aliasing: write 0x12345678 to addr 0x000400, then read addr 0x000000 (ADDR_BITS=10) → data_out=0x12345678.
6. Reset mid-read: accept reads at addrs 1, 2, 3, then assert rst the next cycle → no out_valid after reset; busy=1 for 16 cycles; after that, reading addr 1 returns its pre-reset data.

Source files
------------

// File: rtl/sdram_bram_responder_pkg.sv
// sdram_bram_responder_pkg
// Constants and types shared by the BRAM-backed SDRAM responder and its busy
// timer.
//   SDRAM_ADDR_W / SDRAM_DATA_W : widths of the controller user interface
//   tmr_state_t                 : INIT / RUN / REFRESH states of the busy timer
//   cnt_width()                 : timer counter width helper
package sdram_bram_responder_pkg;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    TMR_INIT    = 2'd0,
    TMR_RUN     = 2'd1,
    TMR_REFRESH = 2'd2
  } tmr_state_t;

  // The counter only ever reaches (terminal count - 1), so clog2 of the largest
  // terminal count is enough. Keep at least one bit for degenerate settings.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sdram_busy_gen.sv
// sdram_busy_gen
// Emulates the availability of a real SDRAM controller. After reset it holds
// busy for an init period. It then alternates between RUN windows, where busy=0,
// and REFRESH windows, where busy=1.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, restarts in INIT
//   busy : registered, 1 while requests must not be accepted
module sdram_busy_gen
  import sdram_bram_responder_pkg::*;
#(
  parameter int INIT_CYCLES    = 16,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  output logic busy
);

  localparam int CNT_W = cnt_width(INIT_CYCLES, REFRESH_PERIOD, REFRESH_CYCLES);

  localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST     = CNT_W'(REFRESH_PERIOD - 1);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);

  tmr_state_t       state;
  logic [CNT_W-1:0] cnt;

  // busy is set together with each state transition, so it always matches the
  // state that is entered on the same edge. On the last RUN cycle busy is still
  // 0, and a request presented then is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TMR_INIT;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        TMR_INIT: begin
          if (cnt == INIT_LAST) begin
            state <= TMR_RUN;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TMR_RUN: begin
          if (cnt == RUN_LAST) begin
            state <= TMR_REFRESH;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TMR_REFRESH: begin
          if (cnt == REFRESH_LAST) begin
            state <= TMR_RUN;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= TMR_INIT;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/sdram_bram_responder.sv
// sdram_bram_responder
// Responder side of the SDRAM controller user interface, backed by block RAM.
// It mimics controller timing with an init hold-off, periodic refresh stalls and
// a fixed read latency. Memory clients can then run without the SDRAM shield.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset; memory contents are preserved
//   addr      : word address (only the low ADDR_BITS bits are decoded)
//   rw        : 1 = write, 0 = read
//   data_in   : write data
//   in_valid  : request strobe, accepted when busy=0
//   busy      : registered, responder cannot accept a request this cycle
//   data_out  : read data, holds its last value between responses
//   out_valid : one-cycle pulse per read, READ_LATENCY cycles after accept
module sdram_bram_responder
  import sdram_bram_responder_pkg::*;
#(
  parameter int ADDR_BITS      = 10,
  parameter int READ_LATENCY   = 3,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 8,
  parameter int INIT_CYCLES    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SDRAM_ADDR_W-1:0] addr,
  input  logic                    rw,
  input  logic [SDRAM_DATA_W-1:0] data_in,
  input  logic                    in_valid,
  output logic                    busy,
  output logic [SDRAM_DATA_W-1:0] data_out,
  output logic                    out_valid
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [SDRAM_DATA_W-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]    word_idx;
  logic                    accept;
  logic                    wr_accept;
  logic                    rd_accept;
  logic [SDRAM_DATA_W-1:0] rd_word;

  sdram_busy_gen #(
    .INIT_CYCLES   (INIT_CYCLES),
    .REFRESH_PERIOD(REFRESH_PERIOD),
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_busy_gen (
    .clk (clk),
    .rst (rst),
    .busy(busy)
  );

  // Upper address bits are intentionally ignored, so addresses alias modulo the
  // depth.
  assign word_idx = addr[ADDR_BITS-1:0];

  generate
    if (ADDR_BITS < SDRAM_ADDR_W) begin : g_alias
      logic unused_upper_addr;
      assign unused_upper_addr = ^addr[SDRAM_ADDR_W-1:ADDR_BITS];
    end
  endgenerate

  // Gating with rst keeps a request that arrives in the first reset cycle,
  // while busy may still read 0, from touching memory or the pipeline.
  assign accept    = in_valid && !busy && !rst;
  assign wr_accept = accept && rw;
  assign rd_accept = accept && !rw;
  assign rd_word   = mem[word_idx];

  // Memory is not reset. A write lands at the edge ending its accept cycle,
  // so a read on the following cycle sees the new data.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[word_idx] <= data_in;
    end
  end

  logic [READ_LATENCY-1:0] vld_pipe;
  logic [READ_LATENCY-1:0] vld_in;
  logic [SDRAM_DATA_W-1:0] dat_pipe [READ_LATENCY];
  logic [SDRAM_DATA_W-1:0] dat_in   [READ_LATENCY];

  // Stage 0 captures the read at its accept edge. The last stage is the output
  // register, so the latency holds even when READ_LATENCY is 1.
  assign vld_in = READ_LATENCY'({vld_pipe, rd_accept});

  generate
    for (genvar g = 0; g < READ_LATENCY; g++) begin : g_stage
      if (g == 0) begin : g_first
        assign dat_in[g] = rd_word;
      end else begin : g_next
        assign dat_in[g] = dat_pipe[g-1];
      end
    end
  endgenerate

  // Intermediate data stages shift every cycle. The output stage only loads
  // when a valid read arrives, so data_out holds between responses. Reset drops
  // all in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_pipe[i] <= '0;
      end
    end else begin
      vld_pipe <= vld_in;
      for (int i = 0; i < READ_LATENCY; i++) begin
        if ((i != READ_LATENCY - 1) || vld_in[i]) begin
          dat_pipe[i] <= dat_in[i];
        end
      end
    end
  end

  assign out_valid = vld_pipe[READ_LATENCY-1];
  assign data_out  = dat_pipe[READ_LATENCY-1];

endmodule
